// File: rtl/master_out_port_pkg.sv
// Shared types and widths for the serial bus master transmit port.
// Burst decoding lives here so the bench-facing meaning of the field is defined once.
package master_out_port_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 13;
  localparam int BEAT_W  = BURST_W;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_REQ,
    ADDR_TX,
    DATA_WAIT,
    DATA_REQ,
    DATA_TX
  } state_t;

  // An enabled burst carries "extra beats" in its upper bits; 4096 beats needs 13 bits.
  function automatic logic [BEAT_W-1:0] beats_from_burst(input logic [BURST_W-1:0] b);
    if (b[0]) begin
      return {1'b0, b[BURST_W-1:1]} + BEAT_W'(1);
    end
    return BEAT_W'(1);
  endfunction

endpackage

// File: rtl/master_out_port_if.sv
// Serial bus between the master transmit port and the slave receive port.
interface master_out_port_if;
  import master_out_port_pkg::*;

  logic               m_valid;
  logic               s_ready;
  logic               tx_address;
  logic               tx_data;
  logic               read_enable;
  logic               write_enable;
  logic [BURST_W-1:0] burst;
  logic               tx_done;

  modport master (
    output m_valid, tx_address, tx_data, read_enable, write_enable, burst, tx_done,
    input  s_ready
  );

  modport slave (
    input  m_valid, tx_address, tx_data, read_enable, write_enable, burst, tx_done,
    output s_ready
  );

endinterface

// File: rtl/master_out_port_piso_shift.sv
// Parallel-in serial-out register, LSB first, with a bit counter flagging the last bit.
module master_out_port_piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  output logic         dout,
  output logic         done
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;

  // Load wins over shift so a fresh word always restarts at bit 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= din;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= sreg >> 1;
      cnt  <= cnt + CW'(1);
    end
  end

  assign dout = sreg[0];
  assign done = (cnt == CW'(W - 1));

endmodule

// File: rtl/master_out_port.sv
// Transmit side of the serial bus: takes a command plus write bytes and serialises
// the address and data LSB-first under an m_valid/s_ready handshake.
module master_out_port
  import master_out_port_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic               cmd_write,
  input  logic [BURST_W-1:0] cmd_burst,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  output logic               busy,
  master_out_port_if.master  bus
);

  state_t state, next_state;

  logic [ADDR_W-1:0]  addr_q;
  logic               wr_q;
  logic [BURST_W-1:0] burst_q;
  logic [BEAT_W-1:0]  beats_q;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_next;
  logic               tx_done_q;

  logic addr_bit, addr_done, data_bit, data_done;
  logic handshake, addr_load, addr_shift, data_load, data_shift;
  logic last_addr, last_data, more_beats;

  // s_ready only matters in the two request states; elsewhere it is ignored.
  assign handshake  = ((state == ADDR_REQ) || (state == DATA_REQ)) && bus.s_ready;
  assign addr_load  = (state == IDLE) && cmd_valid;
  assign addr_shift = ((state == ADDR_REQ) && handshake) || (state == ADDR_TX);
  assign data_load  = (state == DATA_WAIT) && wdata_valid;
  assign data_shift = ((state == DATA_REQ) && handshake) || (state == DATA_TX);
  assign last_addr  = (state == ADDR_TX) && addr_done;
  assign last_data  = (state == DATA_TX) && data_done;
  assign beat_next  = beat_cnt + BEAT_W'(1);
  assign more_beats = (beat_next < beats_q);

  master_out_port_piso_shift #(.W(ADDR_W)) u_addr_piso (
    .clk   (clk),
    .rstn  (rstn),
    .load  (addr_load),
    .din   (cmd_addr),
    .shift (addr_shift),
    .dout  (addr_bit),
    .done  (addr_done)
  );

  master_out_port_piso_shift #(.W(DATA_W)) u_data_piso (
    .clk   (clk),
    .rstn  (rstn),
    .load  (data_load),
    .din   (wdata),
    .shift (data_shift),
    .dout  (data_bit),
    .done  (data_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (cmd_valid)   next_state = ADDR_REQ;
      ADDR_REQ:  if (handshake)   next_state = ADDR_TX;
      ADDR_TX:   if (addr_done)   next_state = wr_q ? DATA_WAIT : IDLE;
      DATA_WAIT: if (wdata_valid) next_state = DATA_REQ;
      DATA_REQ:  if (handshake)   next_state = DATA_TX;
      DATA_TX:   if (data_done)   next_state = more_beats ? DATA_WAIT : IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  // Serial lines are forced low outside their own phase so the slave never sees stale bits.
  always_comb begin
    bus.m_valid    = 1'b0;
    bus.tx_address = 1'b0;
    bus.tx_data    = 1'b0;
    wdata_ready    = 1'b0;
    cmd_ready      = (state == IDLE);
    busy           = (state != IDLE);
    unique case (state)
      ADDR_REQ: begin
        bus.m_valid    = 1'b1;
        bus.tx_address = addr_bit;
      end
      ADDR_TX:   bus.tx_address = addr_bit;
      DATA_WAIT: wdata_ready = 1'b1;
      DATA_REQ: begin
        bus.m_valid = 1'b1;
        bus.tx_data = data_bit;
      end
      DATA_TX:   bus.tx_data = data_bit;
      default: ;
    endcase
    bus.read_enable  = busy && !wr_q;
    bus.write_enable = busy && wr_q;
    bus.burst        = busy ? burst_q : '0;
    bus.tx_done      = tx_done_q;
  end

  // tx_done is registered, so it lands the cycle after a beat's final bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q    <= '0;
      wr_q      <= 1'b0;
      burst_q   <= '0;
      beats_q   <= '0;
      beat_cnt  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= (last_addr && !wr_q) || last_data;
      if (addr_load) begin
        addr_q   <= cmd_addr;
        wr_q     <= cmd_write;
        burst_q  <= cmd_burst;
        beats_q  <= beats_from_burst(cmd_burst);
        beat_cnt <= '0;
      end else if (last_data) begin
        beat_cnt <= beat_next;
        if (more_beats) begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

endmodule
